// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - shared width helper and auto-repeat state encoding
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_DELAY  = 2'd2,
        ST_REPEAT = 2'd3
    } rep_state_e;

    // One spare bit above the widest count keeps every terminal value representable.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/conditioner_channel.sv
// rtl/conditioner_channel.sv - one input bit: synchronizer, debouncer, edge pulses, auto-repeat
module conditioner_channel
    import input_conditioner_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic raw_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic press_o
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic             press_q;
    logic             press_d;
    logic             toggle;
    logic [CNT_W-1:0] dcnt_q;
    logic [CNT_W-1:0] dcnt_d;
    logic [CNT_W-1:0] rcnt_q;
    logic [CNT_W-1:0] rcnt_d;
    rep_state_e       state_q;
    rep_state_e       state_d;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Any sample agreeing with the current level restarts the stability window.
    always_comb begin
        dcnt_d = dcnt_q;
        toggle = 1'b0;
        if (sync2_q == level_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == STABLE_LAST) begin
            toggle = 1'b1;
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + CNT_ONE;
        end
        level_d = level_q ^ toggle;
        rise_d  = toggle & ~level_q;
        fall_d  = toggle & level_q;
    end

    // A fall always beats a due repeat tick; dropping repeat_en parks in HELD until the next rise.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        press_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise_d) begin
                    press_d = 1'b1;
                    rcnt_d  = '0;
                    state_d = repeat_en_i ? ST_DELAY : ST_HELD;
                end
            end
            ST_HELD: begin
                if (fall_d) state_d = ST_IDLE;
            end
            ST_DELAY: begin
                if (fall_d) begin
                    state_d = ST_IDLE;
                end else if (!repeat_en_i) begin
                    state_d = ST_HELD;
                end else if (rcnt_q == DELAY_LAST) begin
                    press_d = 1'b1;
                    rcnt_d  = '0;
                    state_d = ST_REPEAT;
                end else begin
                    rcnt_d = rcnt_q + CNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (fall_d) begin
                    state_d = ST_IDLE;
                end else if (!repeat_en_i) begin
                    state_d = ST_HELD;
                end else if (rcnt_q == PERIOD_LAST) begin
                    press_d = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            press_q <= 1'b0;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
            state_q <= ST_IDLE;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            press_q <= press_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
            state_q <= state_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign press_o = press_q;

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - N-channel switch/button conditioner built from per-bit channels
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned CHANNELS      = 21,
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw_in,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] press
);

    localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        conditioner_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clock_i     (clock),
            .reset_i     (reset),
            .raw_i       (raw_in[g]),
            .repeat_en_i (repeat_en[g]),
            .level_o     (level[g]),
            .rise_o      (rise[g]),
            .fall_o      (fall[g]),
            .press_o     (press[g])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - self-checking bench for input_conditioner
module tb_input_conditioner;

    localparam int CH     = 21;
    localparam int STABLE = 4;
    localparam int DELAY  = 10;
    localparam int PERIOD = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] raw_in = '0;
    logic [CH-1:0] repeat_en = '0;
    logic [CH-1:0] level;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] press;

    always #5 clock = ~clock;

    input_conditioner #(
        .CHANNELS      (CH),
        .STABLE_CYCLES (STABLE),
        .REPEAT_DELAY  (DELAY),
        .REPEAT_PERIOD (PERIOD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .raw_in    (raw_in),
        .repeat_en (repeat_en),
        .level     (level),
        .rise      (rise),
        .fall      (fall),
        .press     (press)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: delayed raw samples, mismatch run length, age since rise.
    logic [CH-1:0] m_s1 = '0;
    logic [CH-1:0] m_s2 = '0;
    logic [CH-1:0] m_rep = '0;
    int            m_run[CH];
    int            m_age[CH];
    logic [CH-1:0] e_level = '0;
    logic [CH-1:0] e_rise = '0;
    logic [CH-1:0] e_fall = '0;
    logic [CH-1:0] e_press = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            logic old_s2;
            logic tog;
            e_rise[c]  = 1'b0;
            e_fall[c]  = 1'b0;
            e_press[c] = 1'b0;
            if (reset) begin
                m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_rep[c] = 1'b0;
                e_level[c] = 1'b0; m_run[c] = 0; m_age[c] = 0;
                continue;
            end
            old_s2  = m_s2[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = raw_in[c];
            tog     = 1'b0;
            if (old_s2 != e_level[c]) begin
                m_run[c]++;
                if (m_run[c] == STABLE) begin
                    tog = 1'b1;
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
            if (tog) begin
                e_level[c] = ~e_level[c];
                e_rise[c]  = e_level[c];
                e_fall[c]  = ~e_level[c];
            end
            if (e_rise[c]) begin
                e_press[c] = 1'b1;
                m_age[c]   = 0;
                m_rep[c]   = repeat_en[c];
            end else if (e_fall[c] || !repeat_en[c]) begin
                m_rep[c] = 1'b0;
            end else if (m_rep[c]) begin
                m_age[c]++;
                e_press[c] = (m_age[c] == DELAY) ||
                             (m_age[c] > DELAY && (m_age[c] - DELAY) % PERIOD == 0);
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check("model_level", level, e_level);
        check("model_rise",  rise,  e_rise);
        check("model_fall",  fall,  e_fall);
        check("model_press", press, e_press);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct packed {
        logic raw;
        logic lvl;
        logic rise;
        logic fall;
        logic press;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int   patt[14];
        int   exp_off[5];
        int   poff[8];
        int   t_rise;
        int   np;
        int   fall_off;
        int   act;
        int   r0;
        int   r15;
        int   r1;
        int   p20;

        tbl = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11101,
                5'b11000, 5'b11000, 5'b01000, 5'b01000, 5'b01000, 5'b01000,
                5'b01000, 5'b00010, 5'b00000, 5'b00000};
        patt    = '{1, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        exp_off = '{0, 10, 13, 16, 19};
        for (int c = 0; c < CH; c++) begin
            m_run[c] = 0;
            m_age[c] = 0;
        end

        reset = 1'b1;
        idle(2);
        check("reset_level", level, 0);
        check("reset_press", press, 0);
        reset = 1'b0;
        idle(4);

        // Clean press and release on channel 0, repeat disabled
        for (int k = 0; k < 16; k++) begin
            raw_in[0] = tbl[k].raw;
            step();
            check($sformatf("t1_level_k%0d", k), level[0], tbl[k].lvl);
            check($sformatf("t1_rise_k%0d", k),  rise[0],  tbl[k].rise);
            check($sformatf("t1_fall_k%0d", k),  fall[0],  tbl[k].fall);
            check($sformatf("t1_press_k%0d", k), press[0], tbl[k].press);
        end
        idle(4);

        // Bounce rejection on channel 3
        act = 0;
        for (int k = 0; k < 14; k++) begin
            raw_in[3] = (patt[k] != 0);
            step();
            act = act | int'(level[3] | rise[3] | fall[3] | press[3]);
        end
        check("t2_bounce_quiet", act, 0);
        raw_in[3] = 1'b1;
        np = 0; t_rise = -1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (rise[3]) begin
                np++;
                if (t_rise < 0) t_rise = k;
            end
        end
        check("t2_rise_count", np, 1);
        check("t2_rise_edge", t_rise, 6);
        raw_in[3] = 1'b0;
        idle(8);

        // Auto-repeat on channel 20; release so the fall lands on tick T+22
        repeat_en[20] = 1'b1;
        raw_in[20]    = 1'b1;
        t_rise = -1; np = 0; fall_off = -1;
        for (int k = 1; k <= 40; k++) begin
            if (t_rise >= 0 && k == t_rise + 17) raw_in[20] = 1'b0;
            step();
            if (rise[20] && t_rise < 0) t_rise = k;
            if (press[20] && t_rise >= 0) begin
                if (np < 8) poff[np] = k - t_rise;
                np++;
            end
            if (fall[20] && t_rise >= 0 && fall_off < 0) fall_off = k - t_rise;
        end
        check("t3_rise_edge", t_rise, 6);
        check("t3_press_count", np, 5);
        for (int i = 0; i < 5; i++)
            if (i < np) check($sformatf("t3_press_off%0d", i), poff[i], exp_off[i]);
        check("t3_fall_off", fall_off, 22);
        repeat_en[20] = 1'b0;
        idle(4);

        // Repeat cancelled during DELAY on channel 5, then a fresh press
        repeat_en[5] = 1'b1;
        raw_in[5]    = 1'b1;
        t_rise = -1; np = 0;
        for (int k = 1; k <= 30; k++) begin
            if (t_rise >= 0 && k == t_rise + 7) repeat_en[5] = 1'b0;
            step();
            if (rise[5] && t_rise < 0) t_rise = k;
            if (press[5]) np++;
        end
        check("t4_cancel_presses", np, 1);
        raw_in[5] = 1'b0;
        idle(10);
        repeat_en[5] = 1'b1;
        raw_in[5]    = 1'b1;
        np = 0; t_rise = -1;
        for (int k = 1; k <= 18; k++) begin
            step();
            if (press[5]) begin
                if (np < 8) poff[np] = k;
                np++;
            end
        end
        check("t4_fresh_count", np, 2);
        check("t4_fresh_first", poff[0], 6);
        check("t4_fresh_second", poff[1], 16);
        raw_in[5] = 1'b0; repeat_en[5] = 1'b0;
        idle(10);

        // Reset during channel 1 debounce and channel 20 REPEAT
        repeat_en[20] = 1'b1;
        raw_in[20]    = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 17) raw_in[1] = 1'b1;
            step();
        end
        reset = 1'b1;
        step();
        check("t5_rst_level", level, 0);
        check("t5_rst_rise", rise, 0);
        check("t5_rst_fall", fall, 0);
        check("t5_rst_press", press, 0);
        reset = 1'b0;
        r1 = -1; t_rise = -1; p20 = -1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (rise[20] && t_rise < 0) t_rise = k;
            if (press[20] && p20 < 0) p20 = k;
            if (rise[1] && r1 < 0) r1 = k;
        end
        check("t5_rise20_edge", t_rise, 6);
        check("t5_press20_edge", p20, 6);
        check("t5_rise1_edge", r1, 6);
        raw_in = '0; repeat_en = '0;
        idle(10);

        // Channels 0 and 15 together while channel 7 chatters
        raw_in[0] = 1'b1; raw_in[15] = 1'b1;
        r0 = -1; r15 = -1; act = 0;
        for (int k = 1; k <= 12; k++) begin
            raw_in[7] = k[0];
            step();
            if (rise[0] && r0 < 0) r0 = k;
            if (rise[15] && r15 < 0) r15 = k;
            act = act | int'(level[7] | rise[7] | fall[7] | press[7]);
        end
        check("t6_rise0_edge", r0, 6);
        check("t6_rise15_edge", r15, 6);
        check("t6_ch7_quiet", act, 0);
        raw_in = '0;
        idle(10);

        // Randomised traffic against the model
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 7) == 0) raw_in[c] = ~raw_in[c];
                if ($urandom_range(0, 63) == 0) repeat_en[c] = ~repeat_en[c];
            end
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
